// File: rtl/mips_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile_arbiter
//  Description : Shares a 32-entry MIPS register file (2 read ports, 1 write
//                port, registered read data) between the R-type datapath (A)
//                and the debug/initialisation loader (B). Each accepted
//                transaction reads two registers and optionally writes one
//                in a single register-file access cycle. Round-robin
//                arbitration; optional write protection of register $zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter bit ZERO_PROTECT = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,

   // Requester A: R-type datapath operand fetch / writeback
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic [ADDR_W-1:0] a_rs,
   input  logic [ADDR_W-1:0] a_rt,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              a_we,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rdata_1,
   output logic [DATA_W-1:0] a_rdata_2,

   // Requester B: debug / initialisation loader
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic [ADDR_W-1:0] b_rs,
   input  logic [ADDR_W-1:0] b_rt,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              b_we,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rdata_1,
   output logic [DATA_W-1:0] b_rdata_2,

   // Register-file side
   output logic [ADDR_W-1:0] rf_read_reg_1,
   output logic [ADDR_W-1:0] rf_read_reg_2,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_reg_write,
   input  logic [DATA_W-1:0] rf_read_data_1,
   input  logic [DATA_W-1:0] rf_read_data_2
);

   // IDLE: arbitrate and accept; ACCESS: drive the register file for one
   // cycle; RESPOND: registered read data is valid and is captured.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic   grant_b;       // arbitration result in IDLE (0 = A, 1 = B)
   logic   owner_b;       // requester owning the transaction in flight
   logic   last_grant_b;  // owner of the most recently completed transaction
   logic   we_q;          // latched write request
   logic   handshake;     // a request is accepted this cycle
   logic   write_allow;   // latched write survives $zero protection

   // Round-robin choice: a lone requester wins; a tie goes to whoever was
   // not served last.
   always_comb begin
      grant_b = 1'b0;
      if (a_req_valid && !b_req_valid) begin
         grant_b = 1'b0;
      end else if (b_req_valid && !a_req_valid) begin
         grant_b = 1'b1;
      end else if (a_req_valid && b_req_valid) begin
         grant_b = ~last_grant_b;
      end
   end

   // A write to register 0 is dropped when protection is enabled.
   assign write_allow = we_q & ~(ZERO_PROTECT && (rf_write_reg == '0));

   // Next-state and FSM-decoded outputs. Ready is qualified with reset_n so
   // every output reads 0 while reset is held, even with valid asserted.
   always_comb begin
      state_nxt    = state;
      a_req_ready  = 1'b0;
      b_req_ready  = 1'b0;
      rf_reg_write = 1'b0;
      case (state)
         ST_IDLE: begin
            a_req_ready = reset_n & a_req_valid & ~grant_b;
            b_req_ready = reset_n & b_req_valid &  grant_b;
            if (a_req_valid || b_req_valid) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            rf_reg_write = write_allow;
            state_nxt    = ST_RESPOND;
         end
         ST_RESPOND: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign handshake = a_req_ready | b_req_ready;

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request capture at handshake; these registers drive the register-file
   // indices directly, so they hold their value outside ACCESS.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_b       <= 1'b0;
         we_q          <= 1'b0;
         rf_read_reg_1 <= '0;
         rf_read_reg_2 <= '0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
      end else if (handshake) begin
         owner_b       <= grant_b;
         we_q          <= grant_b ? b_we    : a_we;
         rf_read_reg_1 <= grant_b ? b_rs    : a_rs;
         rf_read_reg_2 <= grant_b ? b_rt    : a_rt;
         rf_write_reg  <= grant_b ? b_rd    : a_rd;
         rf_write_data <= grant_b ? b_wdata : a_wdata;
      end
   end

   // Response capture at the close of RESPOND: route read data to the owner,
   // pulse its rsp_valid for one cycle and record it for round-robin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_rsp_valid  <= 1'b0;
         b_rsp_valid  <= 1'b0;
         a_rdata_1    <= '0;
         a_rdata_2    <= '0;
         b_rdata_1    <= '0;
         b_rdata_2    <= '0;
         last_grant_b <= 1'b1;
      end else begin
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         if (state == ST_RESPOND) begin
            last_grant_b <= owner_b;
            if (owner_b) begin
               b_rsp_valid <= 1'b1;
               b_rdata_1   <= rf_read_data_1;
               b_rdata_2   <= rf_read_data_2;
            end else begin
               a_rsp_valid <= 1'b1;
               a_rdata_1   <= rf_read_data_1;
               a_rdata_2   <= rf_read_data_2;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_regfile_arbiter
//  Description : Directed bench for mips_regfile_arbiter with a behavioural
//                32x32 register file (registered read, read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic        a_req_ready, b_req_ready;
   logic [4:0]  a_rs = '0, a_rt = '0, a_rd = '0, b_rs = '0, b_rt = '0, b_rd = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        a_we = 1'b0, b_we = 1'b0;
   logic        a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rdata_1, a_rdata_2, b_rdata_1, b_rdata_2;
   logic [4:0]  rf_read_reg_1, rf_read_reg_2, rf_write_reg;
   logic [31:0] rf_write_data;
   logic        rf_reg_write;
   logic [31:0] rf_read_data_1 = '0, rf_read_data_2 = '0;
   logic        rf_clear = 1'b1;
   logic [31:0] regs [32];

   int vectors = 0;
   int miscompares = 0;

   mips_regfile_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_PROTECT(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
      .a_rs(a_rs), .a_rt(a_rt), .a_rd(a_rd), .a_wdata(a_wdata), .a_we(a_we),
      .a_rsp_valid(a_rsp_valid), .a_rdata_1(a_rdata_1), .a_rdata_2(a_rdata_2),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
      .b_rs(b_rs), .b_rt(b_rt), .b_rd(b_rd), .b_wdata(b_wdata), .b_we(b_we),
      .b_rsp_valid(b_rsp_valid), .b_rdata_1(b_rdata_1), .b_rdata_2(b_rdata_2),
      .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
      .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .rf_reg_write(rf_reg_write),
      .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2)
   );

   always #5 clk = ~clk;

   // Behavioural register file: registered reads return pre-write contents.
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         rf_read_data_1 <= regs[rf_read_reg_1];
         rf_read_data_2 <= regs[rf_read_reg_2];
         if (rf_reg_write) regs[rf_write_reg] <= rf_write_data;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic apply_reset();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      reset_n     = 1'b0;
      rf_clear    = 1'b1;
      repeat (3) @(negedge clk);
      rf_clear = 1'b0;
      reset_n  = 1'b1;
   endtask

   // Drive one transaction and report what was observed; no judgement here.
   task automatic run_txn(input bit is_b, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] wd, input bit we,
                          output bit ok, output int waited, output int we_cyc,
                          output bit rsp_ok, output logic [31:0] d1, output logic [31:0] d2);
      bit rdy, own, oth;
      @(negedge clk);
      if (is_b) begin
         b_req_valid = 1'b1; b_rs = rs; b_rt = rt; b_rd = rd; b_wdata = wd; b_we = we;
      end else begin
         a_req_valid = 1'b1; a_rs = rs; a_rt = rt; a_rd = rd; a_wdata = wd; a_we = we;
      end
      #1;
      waited = 0;
      rdy = is_b ? b_req_ready : a_req_ready;
      while (!rdy && waited < 10) begin
         @(negedge clk); #1;
         waited++;
         rdy = is_b ? b_req_ready : a_req_ready;
      end
      ok = rdy; we_cyc = 0; rsp_ok = 1'b0; d1 = '0; d2 = '0;
      if (!rdy) begin
         a_req_valid = 1'b0; b_req_valid = 1'b0;
         return;
      end
      rsp_ok = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // Scramble inputs after acceptance: the DUT must have latched them.
            a_req_valid = 1'b0; b_req_valid = 1'b0;
            a_rs = ~rs; a_rt = ~rt; a_rd = ~rd; a_wdata = ~wd; a_we = ~we;
            b_rs = ~rs; b_rt = ~rt; b_rd = ~rd; b_wdata = ~wd; b_we = ~we;
         end
         #1;
         if (rf_reg_write) we_cyc++;
         own = is_b ? b_rsp_valid : a_rsp_valid;
         oth = is_b ? a_rsp_valid : b_rsp_valid;
         if (oth) rsp_ok = 1'b0;
         if (own != (k == 3)) rsp_ok = 1'b0;
      end
      d1 = is_b ? b_rdata_1 : a_rdata_1;
      d2 = is_b ? b_rdata_2 : a_rdata_2;
      a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; rf_clear = 1'b1;
      a_req_valid = 1'b1; b_req_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if ({a_req_ready, b_req_ready} !== 2'b00) begin
         miscompares++; $display("FAIL reset_ready: got %b expected 00", {a_req_ready, b_req_ready});
      end
      vectors++;
      if ({a_rsp_valid, b_rsp_valid, rf_reg_write} !== 3'b000) begin
         miscompares++; $display("FAIL reset_valids: got %b expected 000", {a_rsp_valid, b_rsp_valid, rf_reg_write});
      end
      vectors++;
      if ({a_rdata_1, a_rdata_2, b_rdata_1, b_rdata_2} !== 128'h0) begin
         miscompares++; $display("FAIL reset_rdata: got %h expected 0", {a_rdata_1, a_rdata_2, b_rdata_1, b_rdata_2});
      end
      vectors++;
      if ({rf_read_reg_1, rf_read_reg_2, rf_write_reg, rf_write_data} !== 47'h0) begin
         miscompares++; $display("FAIL reset_rf_outputs: got %h expected 0", {rf_read_reg_1, rf_read_reg_2, rf_write_reg, rf_write_data});
      end
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      @(negedge clk);
      rf_clear = 1'b0; reset_n = 1'b1;
   endtask

   task automatic test_basic_write_read();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      run_txn(1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b1, 5'd0, 5'd0, 5'd2, 32'd7, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b0, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!ok || waited != 0) begin
         miscompares++; $display("FAIL basic_ready: accepted=%0d waited=%0d expected 1/0", ok, waited);
      end
      vectors++;
      if (we_cyc != 1) begin
         miscompares++; $display("FAIL basic_write_pulse: got %0d cycles expected 1", we_cyc);
      end
      vectors++;
      if (!rsp_ok || d1 !== 32'd5 || d2 !== 32'd7) begin
         miscompares++; $display("FAIL basic_response: rsp_ok=%0d got %h/%h expected 5/7", rsp_ok, d1, d2);
      end
      run_txn(1'b1, 5'd3, 5'd3, 5'd0, 32'd0, 1'b0, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL basic_readback_r3: got %h/%h expected deadbeef", d1, d2);
      end
   endtask

   task automatic test_zero_protect();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      run_txn(1'b1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || we_cyc != 0) begin
         miscompares++; $display("FAIL zero_write_blocked: rsp_ok=%0d write cycles %0d expected 0", rsp_ok, we_cyc);
      end
      run_txn(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'd0 || d2 !== 32'd0) begin
         miscompares++; $display("FAIL zero_readback: got %h/%h expected 0/0", d1, d2);
      end
   endtask

   task automatic test_read_before_write();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      run_txn(1'b1, 5'd0, 5'd0, 5'd4, 32'h99, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b0, 5'd4, 5'd1, 5'd4, 32'h12, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'h99 || d2 !== 32'd5 || we_cyc != 1) begin
         miscompares++; $display("FAIL rbw_old_value: got %h/%h we=%0d expected 99/5 we=1", d1, d2, we_cyc);
      end
      run_txn(1'b0, 5'd4, 5'd3, 5'd0, 32'd0, 1'b0, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'h12 || d2 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL rbw_new_value: got %h/%h expected 12/deadbeef", d1, d2);
      end
   endtask

   task automatic test_read_only_b();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      run_txn(1'b1, 5'd3, 5'd1, 5'd6, 32'h55, 1'b0, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'hDEADBEEF || d2 !== 32'd5) begin
         miscompares++; $display("FAIL readonly_b_data: got %h/%h expected deadbeef/5", d1, d2);
      end
      vectors++;
      if (we_cyc != 0) begin
         miscompares++; $display("FAIL readonly_b_nowrite: got %0d write cycles expected 0", we_cyc);
      end
      vectors++;
      if (a_rdata_1 !== 32'h12 || a_rdata_2 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL readonly_a_held: got %h/%h expected 12/deadbeef", a_rdata_1, a_rdata_2);
      end
   endtask

   task automatic test_reset_mid_access();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      @(negedge clk);
      a_req_valid = 1'b1; a_rs = 5'd0; a_rt = 5'd0; a_rd = 5'd5; a_wdata = 32'hAAAA5555; a_we = 1'b1;
      #1;
      vectors++;
      if (a_req_ready !== 1'b1) begin
         miscompares++; $display("FAIL midrst_accept: got %b expected 1", a_req_ready);
      end
      @(negedge clk);                     // ACCESS cycle
      a_req_valid = 1'b0; a_we = 1'b0;
      #1;
      vectors++;
      if (rf_reg_write !== 1'b1) begin
         miscompares++; $display("FAIL midrst_write_before: got %b expected 1", rf_reg_write);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (rf_reg_write !== 1'b0 || a_rsp_valid !== 1'b0 || a_rdata_1 !== 32'd0 || a_rdata_2 !== 32'd0) begin
         miscompares++; $display("FAIL midrst_clear: we=%b rsp=%b rdata=%h/%h expected 0", rf_reg_write, a_rsp_valid, a_rdata_1, a_rdata_2);
      end
      @(posedge clk);
      #2 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         vectors++;
         if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_no_rsp: cycle %0d got %b%b expected 00", k, a_rsp_valid, b_rsp_valid);
         end
      end
      @(negedge clk);
      a_req_valid = 1'b1; b_req_valid = 1'b1; a_we = 1'b0; b_we = 1'b0;
      #1;
      vectors++;
      if ({a_req_ready, b_req_ready} !== 2'b10) begin
         miscompares++; $display("FAIL midrst_tie_to_a: got %b expected 10", {a_req_ready, b_req_ready});
      end
      a_req_valid = 1'b0; b_req_valid = 1'b0;  // withdrawn before the edge: no effect
      run_txn(1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0, ok, waited, we_cyc, rsp_ok, d1, d2);
      vectors++;
      if (!rsp_ok || d1 !== 32'd0 || d2 !== 32'd0) begin
         miscompares++; $display("FAIL midrst_no_write_r5: got %h/%h expected 0/0", d1, d2);
      end
   endtask

   task automatic test_back_to_back();
      bit ok, rsp_ok; int waited, we_cyc; logic [31:0] d1, d2;
      bit pend[$];
      bit exp_b;
      int accepts, rsps, last_acc;
      apply_reset();
      run_txn(1'b1, 5'd0, 5'd0, 5'd1, 32'h11, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b1, 5'd0, 5'd0, 5'd2, 32'h22, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b1, 5'd0, 5'd0, 5'd3, 32'h33, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      run_txn(1'b1, 5'd0, 5'd0, 5'd4, 32'h44, 1'b1, ok, waited, we_cyc, rsp_ok, d1, d2);
      exp_b = 1'b0; accepts = 0; rsps = 0; last_acc = -1;
      @(negedge clk);
      a_req_valid = 1'b1; a_rs = 5'd1; a_rt = 5'd2; a_rd = 5'd0; a_we = 1'b0;
      b_req_valid = 1'b1; b_rs = 5'd3; b_rt = 5'd4; b_rd = 5'd0; b_we = 1'b0;
      for (int cyc = 0; cyc < 40 && !(accepts == 6 && rsps == 6); cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (accepts == 6) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
         #1;
         if (a_rsp_valid || b_rsp_valid) begin
            vectors++;
            if (pend.size() == 0) begin
               miscompares++; $display("FAIL b2b_rsp_unexpected: cycle %0d a=%b b=%b", cyc, a_rsp_valid, b_rsp_valid);
            end else begin
               if (pend[0] ? (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || b_rdata_1 !== 32'h33 || b_rdata_2 !== 32'h44)
                           : (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0 || a_rdata_1 !== 32'h11 || a_rdata_2 !== 32'h22)) begin
                  miscompares++;
                  $display("FAIL b2b_rsp_owner: rsp #%0d got a=%b b=%b a_data=%h/%h b_data=%h/%h expected owner %s", rsps,
                           a_rsp_valid, b_rsp_valid, a_rdata_1, a_rdata_2, b_rdata_1, b_rdata_2, pend[0] ? "B" : "A");
               end
               void'(pend.pop_front());
            end
            rsps++;
         end
         if (a_req_ready || b_req_ready) begin
            vectors++;
            if ({a_req_ready, b_req_ready} !== (exp_b ? 2'b01 : 2'b10) ||
                (last_acc >= 0 && cyc - last_acc != 3)) begin
               miscompares++;
               $display("FAIL b2b_grant: accept #%0d ready=%b gap=%0d expected %s gap 3", accepts,
                        {a_req_ready, b_req_ready}, cyc - last_acc, exp_b ? "B" : "A");
            end
            pend.push_back(exp_b);
            exp_b = ~exp_b;
            accepts++;
            last_acc = cyc;
         end
      end
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      vectors++;
      if (accepts != 6 || rsps != 6) begin
         miscompares++; $display("FAIL b2b_counts: accepts=%0d rsps=%0d expected 6/6", accepts, rsps);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write_read();
      test_zero_protect();
      test_read_before_write();
      test_read_only_b();
      test_reset_mid_access();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
